// File: rtl/tensor_writeback.sv
// Tensor write-back engine: takes a tensor config word, then turns a stream of packed
// words into memory writes at consecutive addresses starting at the tensor base.
module tensor_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [53:0]       config_in_tdata,
    input  logic              config_in_tvalid,
    output logic              config_in_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic              done,
    output logic              error,
    output logic [1:0]        fsm_state
);

    // Handshakes: a transfer happens on the rising clock edge where valid and ready are
    // both high; a source holding valid keeps its payload stable until that edge.
    typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base;
    logic [2:0]        code;
    logic [39:0]       count;
    logic [15:0]       num_words;
    logic [15:0]       wr_cnt;
    logic              last_taken;
    logic              cfg_hs;
    logic              s_hs;
    logic              beat_is_last;
    logic [42:0]       n_ext;
    logic [42:0]       prod;
    logic [42:0]       words_calc;

    assign cfg_hs       = config_in_tvalid & config_in_tready;
    assign s_hs         = s_tvalid & s_tready;
    assign beat_is_last = (wr_cnt == num_words - 16'd1);
    assign fsm_state    = state;

    // Word count per element type; computed at full width, truncated to 16 bits on capture.
    always_comb begin
        n_ext      = {3'b000, count};
        prod       = n_ext * {40'b0, code};
        words_calc = '0;
        case (code)
            3'd0:       words_calc = '0;
            3'd1:       words_calc = (n_ext + 43'd3) >> 2;
            3'd2:       words_calc = (n_ext + 43'd1) >> 1;
            3'd3, 3'd4: words_calc = n_ext;
            default:    words_calc = (prod >> 2) + 43'd1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (cfg_hs) state_next = CALC;
            CALC:  state_next = (words_calc[15:0] == 16'd0) ? DONE : WRITE;
            WRITE: if (last_taken && mem_wvalid && mem_wready) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        config_in_tready = 1'b0;
        s_tready         = 1'b0;
        done             = 1'b0;
        case (state)
            IDLE:  config_in_tready = 1'b1;
            WRITE: s_tready = !last_taken && (!mem_wvalid || mem_wready);
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base       <= '0;
            code       <= '0;
            count      <= '0;
            num_words  <= '0;
            wr_cnt     <= '0;
            last_taken <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_wvalid <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (cfg_hs) begin
                base       <= ADDR_W'(config_in_tdata[53:43]);
                code       <= config_in_tdata[42:40];
                count      <= config_in_tdata[39:0];
                wr_cnt     <= '0;
                last_taken <= 1'b0;
                error      <= 1'b0;
            end
            if (state == CALC) num_words <= words_calc[15:0];
            if (s_hs) begin
                mem_waddr  <= base + ADDR_W'(wr_cnt);
                mem_wdata  <= s_tdata;
                mem_wvalid <= 1'b1;
                wr_cnt     <= wr_cnt + 16'd1;
                // An early tlast ends the tensor too; either disagreement is flagged.
                if (beat_is_last || s_tlast) last_taken <= 1'b1;
                if (beat_is_last != s_tlast) error <= 1'b1;
            end else if (mem_wready) begin
                mem_wvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tensor_writeback.sv
// Directed bench for tensor_writeback: table of tensor configs with hand-computed write
// counts and error flags, plus hand-written stall, zero-length and mid-tensor reset cases.
module tb_tensor_writeback;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [53:0] config_in_tdata = '0;
    logic        config_in_tvalid = 1'b0;
    logic        config_in_tready;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [15:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wvalid;
    logic        mem_wready = 1'b1;
    logic        done;
    logic        error;
    logic [1:0]  fsm_state;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [47:0] exp_q[$];

    typedef struct {
        logic [10:0] base;
        logic [2:0]  code;
        logic [39:0] n;
        int          nbeats;
        int          tlast_idx;
        int          stall_at;
        int          stall_len;
        int          exp_writes;
        logic        exp_err;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    tensor_writeback dut (
        .clock(clock), .reset(reset),
        .config_in_tdata(config_in_tdata), .config_in_tvalid(config_in_tvalid),
        .config_in_tready(config_in_tready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready), .done(done), .error(error), .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input int vi, input int b);
        return {8'(vi), 8'hA5, 8'h5A, 8'(b)};
    endfunction

    // Applies one config, streams beats, models addresses/data and checks every write.
    task automatic run_vec(input int vi);
        vec_t        v;
        int          beat;
        int          writes;
        int          stall_cnt;
        int          last_acc;
        logic        got_done;
        logic        prev_hs;
        logic        prev_stall;
        logic [15:0] prev_addr;
        logic [31:0] prev_data;
        logic [47:0] e;
        v = vecs[vi];
        beat = 0; writes = 0; stall_cnt = 0; last_acc = 0;
        got_done = 1'b0; prev_hs = 1'b0; prev_stall = 1'b0;
        prev_addr = '0; prev_data = '0;
        exp_q.delete();
        @(negedge clock);
        config_in_tdata  = {v.base, v.code, v.n};
        config_in_tvalid = 1'b1;
        s_tvalid = 1'b0;
        mem_wready = 1'b1;
        #1;
        check($sformatf("v%0d_cfg_ready", vi), config_in_tready, 1);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clock);
            config_in_tvalid = 1'b0;
            s_tvalid = (beat < v.nbeats);
            s_tdata  = data_of(vi, beat);
            s_tlast  = (beat == v.tlast_idx);
            if (writes == v.stall_at && stall_cnt < v.stall_len) begin
                mem_wready = 1'b0;
                stall_cnt++;
            end else begin
                mem_wready = 1'b1;
            end
            #1;
            if (prev_stall) begin
                check($sformatf("v%0d_stall_valid", vi), mem_wvalid, 1);
                check($sformatf("v%0d_stall_addr", vi), mem_waddr, prev_addr);
                check($sformatf("v%0d_stall_data", vi), mem_wdata, prev_data);
            end
            if (prev_hs) check($sformatf("v%0d_wvalid_latency", vi), mem_wvalid, 1);
            if (mem_wvalid && mem_wready) begin
                check($sformatf("v%0d_write_expected", vi), exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("v%0d_w%0d_addr", vi, writes), mem_waddr, e[47:32]);
                    check($sformatf("v%0d_w%0d_data", vi, writes), mem_wdata, e[31:0]);
                end
                writes++;
                last_acc = cyc;
            end
            if (mem_wvalid && !mem_wready)
                check($sformatf("v%0d_stall_s_tready", vi), s_tready, 0);
            if (done) begin
                got_done = 1'b1;
                check($sformatf("v%0d_done_wvalid", vi), mem_wvalid, 0);
                check($sformatf("v%0d_writes", vi), writes, v.exp_writes);
                check($sformatf("v%0d_beats", vi), beat, v.exp_writes);
                check($sformatf("v%0d_queue_left", vi), exp_q.size(), 0);
                check($sformatf("v%0d_error", vi), error, v.exp_err);
                if (v.exp_writes == 0) check($sformatf("v%0d_done_latency", vi), cyc, 2);
                else check($sformatf("v%0d_done_after_write", vi), cyc - last_acc, 1);
                break;
            end
            prev_hs = s_tvalid && s_tready;
            if (prev_hs) begin
                exp_q.push_back({16'(int'(v.base) + beat), data_of(vi, beat)});
                beat++;
            end
            prev_stall = mem_wvalid && !mem_wready;
            prev_addr  = mem_waddr;
            prev_data  = mem_wdata;
        end
        check($sformatf("v%0d_done_seen", vi), got_done, 1);
        @(negedge clock);
        s_tvalid = 1'b0;
        mem_wready = 1'b1;
        #1;
        check($sformatf("v%0d_done_one_cycle", vi), done, 0);
        check($sformatf("v%0d_back_idle", vi), config_in_tready, 1);
    endtask

    initial begin
        int hs;
        // base, code, n, beats offered, tlast beat, stall write, stall cycles, writes, error
        vecs[0]  = '{11'h010, 3'd1, 40'd16,      4, 3,  -1, 0, 4, 1'b0};
        vecs[1]  = '{11'h7FF, 3'd3, 40'd3,       3, 2,   1, 3, 3, 1'b0};
        vecs[2]  = '{11'h100, 3'd2, 40'd5,       3, 1,  -1, 0, 2, 1'b1};
        vecs[3]  = '{11'h020, 3'd0, 40'd10,      0, -1, -1, 0, 0, 1'b0};
        vecs[4]  = '{11'h200, 3'd5, 40'd4,       6, -1, -1, 0, 6, 1'b1};
        vecs[5]  = '{11'h300, 3'd4, 40'd2,       2, 1,  -1, 0, 2, 1'b0};
        vecs[6]  = '{11'h400, 3'd1, 40'd5,       2, 1,  -1, 0, 2, 1'b0};
        vecs[7]  = '{11'h050, 3'd7, 40'd3,       6, 5,  -1, 0, 6, 1'b0};
        vecs[8]  = '{11'h060, 3'd3, 40'd0,       0, -1, -1, 0, 0, 1'b0};
        vecs[9]  = '{11'h070, 3'd6, 40'd1,       2, 1,  -1, 0, 2, 1'b0};
        vecs[10] = '{11'h080, 3'd2, 40'd1,       1, 0,  -1, 0, 1, 1'b0};
        vecs[11] = '{11'h090, 3'd1, 40'h4_0000,  0, -1, -1, 0, 0, 1'b0};
        vecs[12] = '{11'h0A0, 3'd4, 40'd3,       5, -1,  1, 2, 3, 1'b1};
        vecs[13] = '{11'h0B0, 3'd3, 40'd4,       4, 0,  -1, 0, 1, 1'b1};

        repeat (3) @(negedge clock);
        #1;
        check("rst_state", fsm_state, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wvalid", mem_wvalid, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cfg_ready", config_in_tready, 1);
        check("rst_s_tready", s_tready, 0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset in the middle of an 8-word tensor with one write still pending.
        @(negedge clock);
        config_in_tdata  = {11'h040, 3'd3, 40'd8};
        config_in_tvalid = 1'b1;
        hs = 0;
        for (int cyc = 0; cyc < 50 && hs < 2; cyc++) begin
            @(negedge clock);
            config_in_tvalid = 1'b0;
            s_tvalid = 1'b1;
            s_tdata  = data_of(99, hs);
            s_tlast  = 1'b0;
            #1;
            if (s_tvalid && s_tready) hs++;
        end
        check("mid_beats_taken", hs, 2);
        @(negedge clock);
        s_tvalid = 1'b0;
        #1;
        check("mid_pending_write", mem_wvalid, 1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("mid_rst_wvalid", mem_wvalid, 0);
        check("mid_rst_waddr", mem_waddr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_cfg_ready", config_in_tready, 1);
        check("mid_rst_s_tready", s_tready, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("mid_no_done_%0d", i), done, 0);
        end

        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
